// File: rtl/ooo_pkg.sv
// Shared encodings for the out-of-order core's integer execution path.
package ooo_pkg;

  // Dispatch opcodes
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;
  localparam logic [2:0] OP_SLL = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  // Functional-unit FSM states; values are visible on fu_state
  typedef enum logic [1:0] {
    FU_IDLE = 2'd0,
    FU_EXEC = 2'd1,
    FU_WB   = 2'd2
  } fu_state_e;

endpackage

// File: rtl/alu32.sv
// Single-cycle 32-bit integer ALU covering every opcode except MUL.
module alu32
  import ooo_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] result_o
);

  // Result select; MUL is handled by the multiplier path, so it yields zero here
  always_comb begin
    result_o = '0;
    case (op_i)
      OP_ADD:  result_o = a_i + b_i;
      OP_SUB:  result_o = a_i - b_i;
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_SLT:  result_o = ($signed(a_i) < $signed(b_i)) ? 32'd1 : 32'd0;
      OP_SLL:  result_o = a_i << b_i[4:0];
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/exec_unit.sv
// Integer execution unit: 1-cycle ALU, MUL_LAT-cycle multiply, result held until a CDB grant.
module exec_unit
  import ooo_pkg::*;
#(
  parameter int unsigned TAG_WIDTH = 6,
  parameter int unsigned MUL_LAT   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 dispatch_valid,
  input  logic [2:0]           dispatch_op,
  input  logic [31:0]          dispatch_val1,
  input  logic [31:0]          dispatch_val2,
  input  logic [TAG_WIDTH-1:0] dispatch_dest_tag,
  output logic                 dispatch_ack,
  output logic                 cdb_req,
  output logic [TAG_WIDTH-1:0] cdb_tag,
  output logic [31:0]          cdb_data,
  input  logic                 cdb_grant,
  output logic                 fu_busy,
  output logic [1:0]           fu_state,
  output logic [15:0]          ops_done
);

  fu_state_e            state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [31:0]          a_q, a_d, b_q, b_d;
  logic [31:0]          res_q, res_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic [15:0]          ops_done_q, ops_done_d;
  logic [31:0]          alu_res;
  logic [31:0]          mul_res;
  logic                 granted;

  alu32 u_alu (
    .op_i     (dispatch_op),
    .a_i      (dispatch_val1),
    .b_i      (dispatch_val2),
    .result_o (alu_res)
  );

  assign mul_res = a_q * b_q;

  // A grant only counts while a result is actually pending and nothing is being squashed
  assign granted = (state_q == FU_WB) && cdb_grant && !flush;

  assign dispatch_ack = dispatch_valid && !flush &&
                        ((state_q == FU_IDLE) || ((state_q == FU_WB) && cdb_grant));

  // Next-state: flush wins, then drain/advance, then a new acceptance overrides the target
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    tag_d      = tag_q;
    ops_done_d = ops_done_q + {15'd0, granted};

    if (flush) begin
      state_d = FU_IDLE;
    end else begin
      case (state_q)
        FU_IDLE: ;
        FU_EXEC: begin
          if (cnt_q == 4'd1) begin
            res_d   = mul_res;
            state_d = FU_WB;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        FU_WB:   if (cdb_grant) state_d = FU_IDLE;
        default: state_d = FU_IDLE;
      endcase
    end

    if (dispatch_ack) begin
      a_d   = dispatch_val1;
      b_d   = dispatch_val2;
      tag_d = dispatch_dest_tag;
      if (dispatch_op == OP_MUL) begin
        cnt_d   = 4'(MUL_LAT - 1);
        state_d = FU_EXEC;
      end else begin
        res_d   = alu_res;
        state_d = FU_WB;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FU_IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      tag_q      <= '0;
      ops_done_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
      tag_q      <= tag_d;
      ops_done_q <= ops_done_d;
    end
  end

  // Outputs come from registers only; tag/data are masked when nothing is pending
  assign cdb_req  = (state_q == FU_WB);
  assign cdb_tag  = cdb_req ? tag_q : '0;
  assign cdb_data = cdb_req ? res_q : '0;
  assign fu_busy  = (state_q != FU_IDLE);
  assign fu_state = state_q;
  assign ops_done = ops_done_q;

endmodule

// File: tb/tb_exec_unit.sv
// Directed plus randomized checks of exec_unit against a transaction-level reference.
module tb_exec_unit;
  import ooo_pkg::*;

  localparam int unsigned TW  = 6;
  localparam int unsigned LAT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          dispatch_valid;
  logic [2:0]    dispatch_op;
  logic [31:0]   dispatch_val1;
  logic [31:0]   dispatch_val2;
  logic [TW-1:0] dispatch_dest_tag;
  logic          dispatch_ack;
  logic          cdb_req;
  logic [TW-1:0] cdb_tag;
  logic [31:0]   cdb_data;
  logic          cdb_grant;
  logic          fu_busy;
  logic [1:0]    fu_state;
  logic [15:0]   ops_done;

  int checks   = 0;
  int failures = 0;

  // Reference: one pending result with the cycle it becomes visible on the CDB
  bit            m_pend;
  int            m_ready;
  logic [TW-1:0] m_tag;
  logic [31:0]   m_data;
  logic [15:0]   m_ops;
  int            cyc;
  logic [15:0]   saved_ops;

  exec_unit #(
    .TAG_WIDTH (TW),
    .MUL_LAT   (LAT)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .dispatch_valid    (dispatch_valid),
    .dispatch_op       (dispatch_op),
    .dispatch_val1     (dispatch_val1),
    .dispatch_val2     (dispatch_val2),
    .dispatch_dest_tag (dispatch_dest_tag),
    .dispatch_ack      (dispatch_ack),
    .cdb_req           (cdb_req),
    .cdb_tag           (cdb_tag),
    .cdb_data          (cdb_data),
    .cdb_grant         (cdb_grant),
    .fu_busy           (fu_busy),
    .fu_state          (fu_state),
    .ops_done          (ops_done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6:    return a << b[4:0];
      default: return a * b;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [TW-1:0] t, input logic g,
                       input logic f);
    dispatch_valid    = v;
    dispatch_op       = op;
    dispatch_val1     = a;
    dispatch_val2     = b;
    dispatch_dest_tag = t;
    cdb_grant         = g;
    flush             = f;
  endtask

  // Compare every output mid-cycle, then advance the reference across the rising edge
  task automatic tick(input string ph);
    logic       e_req;
    logic       e_ack;
    logic [1:0] e_state;
    @(negedge clk);
    e_req   = !rst && m_pend && (cyc >= m_ready);
    e_ack   = !rst && dispatch_valid && !flush && (!m_pend || (e_req && cdb_grant));
    e_state = (rst || !m_pend) ? 2'd0 : (e_req ? 2'd2 : 2'd1);
    check({ph, ":ack"},   32'(dispatch_ack), 32'(e_ack));
    check({ph, ":req"},   32'(cdb_req),      32'(e_req));
    check({ph, ":tag"},   32'(cdb_tag),      e_req ? 32'(m_tag) : 32'd0);
    check({ph, ":data"},  cdb_data,          e_req ? m_data : 32'd0);
    check({ph, ":busy"},  32'(fu_busy),      32'(e_state != 2'd0));
    check({ph, ":state"}, 32'(fu_state),     32'(e_state));
    check({ph, ":ops"},   32'(ops_done),     32'(m_ops));
    @(posedge clk);
    if (rst) begin
      m_pend = 1'b0;
      m_ops  = '0;
    end else if (flush) begin
      m_pend = 1'b0;
    end else begin
      if (e_req && cdb_grant) begin
        m_ops  = m_ops + 16'd1;
        m_pend = 1'b0;
      end
      if (e_ack) begin
        m_pend  = 1'b1;
        m_ready = cyc + ((dispatch_op == OP_MUL) ? int'(LAT) : 1);
        m_data  = ref_result(dispatch_op, dispatch_val1, dispatch_val2);
        m_tag   = dispatch_dest_tag;
      end
    end
    cyc++;
    #1;
  endtask

  initial begin
    m_pend  = 1'b0;
    m_ready = 0;
    m_tag   = '0;
    m_data  = '0;
    m_ops   = '0;
    cyc     = 0;

    // Reset values
    rst = 1'b1;
    drive(1'b0, OP_ADD, 32'd0, 32'd0, '0, 1'b0, 1'b0);
    #2;
    check("rst_ack",   32'(dispatch_ack), 32'd0);
    check("rst_req",   32'(cdb_req),      32'd0);
    check("rst_tag",   32'(cdb_tag),      32'd0);
    check("rst_data",  cdb_data,          32'd0);
    check("rst_busy",  32'(fu_busy),      32'd0);
    check("rst_state", 32'(fu_state),     32'd0);
    check("rst_ops",   32'(ops_done),     32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ADD 5+7, tag 3, grant held high
    drive(1'b1, OP_ADD, 32'd5, 32'd7, 6'd3, 1'b1, 1'b0);
    tick("add");
    check("add_req",  32'(cdb_req), 32'd1);
    check("add_tag",  32'(cdb_tag), 32'd3);
    check("add_data", cdb_data,     32'd12);
    drive(1'b0, OP_ADD, 32'd0, 32'd0, '0, 1'b1, 1'b0);
    tick("add_wb");
    check("add_ops", 32'(ops_done), 32'd1);

    // SUB then SLT back-to-back
    drive(1'b1, OP_SUB, 32'd3, 32'd5, 6'd4, 1'b1, 1'b0);
    tick("sub");
    check("sub_data", cdb_data, 32'hFFFF_FFFE);
    drive(1'b1, OP_SLT, 32'hFFFF_FFFF, 32'd1, 6'd5, 1'b1, 1'b0);
    tick("slt");
    check("slt_data", cdb_data,     32'd1);
    check("slt_tag",  32'(cdb_tag), 32'd5);
    drive(1'b0, OP_ADD, 32'd0, 32'd0, '0, 1'b1, 1'b0);
    tick("slt_wb");

    // MUL blocks acceptance until its result is granted
    drive(1'b1, OP_MUL, 32'h0001_0000, 32'h0001_0003, 6'd6, 1'b1, 1'b0);
    tick("mul");
    drive(1'b1, OP_ADD, 32'd9, 32'd9, 6'd7, 1'b1, 1'b0);
    repeat (LAT - 2) tick("mul_wait");
    check("mul_req_early", 32'(cdb_req), 32'd0);
    tick("mul_wait");
    check("mul_req",  32'(cdb_req), 32'd1);
    check("mul_data", cdb_data,     32'h0003_0000);
    tick("mul_wb");
    drive(1'b0, OP_ADD, 32'd0, 32'd0, '0, 1'b1, 1'b0);
    tick("mul_add_wb");
    tick("mul_idle");

    // XOR result held while grant is withheld, waiting SLL accepted on grant
    drive(1'b1, OP_XOR, 32'h0000_F0F0, 32'h0000_0FF0, 6'd8, 1'b0, 1'b0);
    tick("xor");
    check("xor_data", cdb_data, 32'h0000_FF00);
    drive(1'b1, OP_SLL, 32'd1, 32'd31, 6'd9, 1'b0, 1'b0);
    repeat (4) begin
      tick("xor_hold");
      check("xor_stable", cdb_data, 32'h0000_FF00);
    end
    drive(1'b1, OP_SLL, 32'd1, 32'd31, 6'd9, 1'b1, 1'b0);
    tick("xor_grant");
    check("sll_data", cdb_data,     32'h8000_0000);
    check("sll_tag",  32'(cdb_tag), 32'd9);
    drive(1'b0, OP_ADD, 32'd0, 32'd0, '0, 1'b1, 1'b0);
    tick("sll_wb");

    // Flush during multiply execution
    saved_ops = ops_done;
    drive(1'b1, OP_MUL, 32'd3, 32'd4, 6'd10, 1'b1, 1'b0);
    tick("fl_mul");
    drive(1'b0, OP_ADD, 32'd0, 32'd0, '0, 1'b1, 1'b1);
    tick("fl_exec");
    check("fl_state", 32'(fu_state), 32'd0);
    drive(1'b0, OP_ADD, 32'd0, 32'd0, '0, 1'b1, 1'b0);
    repeat (LAT + 1) tick("fl_after");
    check("fl_ops", 32'(ops_done), 32'(saved_ops));

    // Flush coinciding with grant in WB
    drive(1'b1, OP_ADD, 32'd2, 32'd3, 6'd11, 1'b1, 1'b0);
    tick("flg_add");
    drive(1'b1, OP_ADD, 32'd4, 32'd4, 6'd12, 1'b1, 1'b1);
    tick("flg_wb");
    check("flg_ops",   32'(ops_done), 32'(saved_ops));
    check("flg_state", 32'(fu_state), 32'd0);

    // Asynchronous reset while a result waits in WB
    drive(1'b1, OP_ADD, 32'd6, 32'd6, 6'd13, 1'b0, 1'b0);
    tick("ar_add");
    drive(1'b0, OP_ADD, 32'd0, 32'd0, '0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("ar_req",   32'(cdb_req),  32'd0);
    check("ar_busy",  32'(fu_busy),  32'd0);
    check("ar_state", 32'(fu_state), 32'd0);
    check("ar_tag",   32'(cdb_tag),  32'd0);
    check("ar_data",  cdb_data,      32'd0);
    m_pend = 1'b0;
    m_ops  = '0;
    tick("ar_hold");
    rst = 1'b0;
    drive(1'b1, OP_ADD, 32'd1, 32'd1, 6'd14, 1'b1, 1'b0);
    tick("ar_post");
    check("ar_post_data", cdb_data,     32'd2);
    check("ar_post_tag",  32'(cdb_tag), 32'd14);
    drive(1'b0, OP_ADD, 32'd0, 32'd0, '0, 1'b1, 1'b0);
    tick("ar_post_wb");
    check("ar_post_ops", 32'(ops_done), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 3'($urandom), $urandom, $urandom, TW'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
      tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
